// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding/hazard unit: ALU operand mux select
// encodings, hazard FSM states and the default register address width.
package fwd_hazard_unit_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ALU_MUX_DATA_FROM_REG       = 2'b00,
    ALU_MUX_DATA_FROM_ALU_MEM   = 2'b01,
    ALU_MUX_DATA_FROM_MEM_WB    = 2'b10,
    ALU_MUX_DATA_FROM_WB_BYPASS = 2'b11
  } alu_mux_sel_e;

  typedef enum logic {
    HZ_IDLE     = 1'b0,
    HZ_LU_STALL = 1'b1
  } hz_state_e;

  // A source hits a producer stage when it is read, the stage writes, and the
  // addresses agree on a non-zero register.
  function automatic logic src_hit(input logic used, input logic we, input logic addr_eq,
                                   input logic addr_nz);
    return used & we & addr_eq & addr_nz;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_fwd_src_cmp.sv
// Per-source priority compare against the EX / MEM (/ WB) destinations.
// FWD_WB_BYPASS_EN adds a WB match level below MEM.
module fwd_src_cmp
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_used,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_we,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_we,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_we,
  output logic [1:0]            o_sel,
  output logic                  o_ex_match
);

  logic w_nz;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_nz      = (i_rs != {REG_ADDR_W{1'b0}});
  assign w_ex_hit  = src_hit(i_used, i_ex_we, (i_rs == i_ex_rd), w_nz);
  assign w_mem_hit = src_hit(i_used, i_mem_we, (i_rs == i_mem_rd), w_nz);

`ifdef FWD_WB_BYPASS_EN
  assign w_wb_hit = src_hit(i_used, i_wb_we, (i_rs == i_wb_rd), w_nz);
`else
  // Register file bypasses internally; WB destination is irrelevant here.
  logic w_unused_wb;
  assign w_unused_wb = ^{i_wb_rd, i_wb_we};
  assign w_wb_hit    = 1'b0;
`endif

  assign o_ex_match = w_ex_hit;

  // Nearest producer wins: EX, then MEM, then WB.
  always_comb begin
    o_sel = ALU_MUX_DATA_FROM_REG;
    if (w_ex_hit) begin
      o_sel = ALU_MUX_DATA_FROM_ALU_MEM;
    end else if (w_mem_hit) begin
      o_sel = ALU_MUX_DATA_FROM_MEM_WB;
    end else if (w_wb_hit) begin
      o_sel = ALU_MUX_DATA_FROM_WB_BYPASS;
    end else begin
      o_sel = ALU_MUX_DATA_FROM_REG;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding + hazard unit between ID and EX: registered operand mux selects,
// load-use stall/bubble and multi-cycle occupancy. Optional: FWD_WB_BYPASS_EN.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int NUM_SRC    = 2,
  parameter int MC_LAT     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          ex_we,
  input  logic                          ex_is_load,
  input  logic                          ex_mc_start,
  input  logic [REG_ADDR_W-1:0]         mem_rd,
  input  logic                          mem_we,
  input  logic [REG_ADDR_W-1:0]         wb_rd,
  input  logic                          wb_we,
  output logic [NUM_SRC*2-1:0]          fwd_sel,
  output logic                          stall,
  output logic                          ex_bubble,
  output logic                          mc_busy
);

  localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 1);

  hz_state_e              r_state;
  hz_state_e              w_state_nxt;
  logic [CNT_W-1:0]       r_mc_cnt;
  logic [NUM_SRC*2-1:0]   r_fwd_sel;
  logic [NUM_SRC*2-1:0]   w_sel_nxt;
  logic [NUM_SRC-1:0]     w_ex_match;
  logic                   w_lu_raw;
  logic                   w_lu_hazard;
  logic                   w_mc_busy;
  logic                   w_stall;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_cmp #(
      .REG_ADDR_W (REG_ADDR_W)
    ) u_cmp (
      .i_rs       (id_rs_addr[g*REG_ADDR_W +: REG_ADDR_W]),
      .i_used     (id_rs_used[g]),
      .i_ex_rd    (ex_rd),
      .i_ex_we    (ex_we),
      .i_mem_rd   (mem_rd),
      .i_mem_we   (mem_we),
      .i_wb_rd    (wb_rd),
      .i_wb_we    (wb_we),
      .o_sel      (w_sel_nxt[g*2 +: 2]),
      .o_ex_match (w_ex_match[g])
    );
  end

  assign w_lu_raw  = id_valid & ex_is_load & (|w_ex_match);
  assign w_mc_busy = (r_mc_cnt != {CNT_W{1'b0}});
  assign w_stall   = w_lu_hazard | w_mc_busy;

  // Hazard FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HZ_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a load-use stall is taken once; while busy the FSM waits in IDLE
  // so the hazard is re-evaluated after the multi-cycle op releases.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HZ_IDLE: begin
        if (w_lu_raw && !w_mc_busy) begin
          w_state_nxt = HZ_LU_STALL;
        end else begin
          w_state_nxt = HZ_IDLE;
        end
      end
      HZ_LU_STALL: w_state_nxt = HZ_IDLE;
      default:     w_state_nxt = HZ_IDLE;
    endcase
  end

  // FSM outputs: the hazard is masked in the cycle after the stall.
  always_comb begin
    w_lu_hazard = 1'b0;
    case (r_state)
      HZ_IDLE:     w_lu_hazard = w_lu_raw;
      HZ_LU_STALL: w_lu_hazard = 1'b0;
      default:     w_lu_hazard = 1'b0;
    endcase
  end

  // Multi-cycle occupancy counter; a start while busy is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mc_cnt <= {CNT_W{1'b0}};
    end else if (w_mc_busy) begin
      r_mc_cnt <= r_mc_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (ex_mc_start) begin
      r_mc_cnt <= CNT_LOAD;
    end else begin
      r_mc_cnt <= {CNT_W{1'b0}};
    end
  end

  // EX-stage mux selects; a bubble or stalled slot carries no forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_sel <= {(NUM_SRC*2){1'b0}};
    end else if (id_valid && !w_stall) begin
      r_fwd_sel <= w_sel_nxt;
    end else begin
      r_fwd_sel <= {(NUM_SRC*2){1'b0}};
    end
  end

  assign fwd_sel   = r_fwd_sel;
  assign mc_busy   = w_mc_busy;
  assign stall     = w_stall;
  assign ex_bubble = w_lu_hazard & ~w_mc_busy;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios then random traffic
// against a cycle-level reference model.
module tb_fwd_hazard_unit;

  localparam int W   = 5;
  localparam int NS  = 2;
  localparam int MCL = 4;

`ifdef FWD_WB_BYPASS_EN
  localparam logic [1:0] WB_ONLY_EXP = 2'b11;
`else
  localparam logic [1:0] WB_ONLY_EXP = 2'b00;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [NS*W-1:0] id_rs_addr;
  logic [NS-1:0]   id_rs_used;
  logic [W-1:0]    ex_rd;
  logic            ex_we;
  logic            ex_is_load;
  logic            ex_mc_start;
  logic [W-1:0]    mem_rd;
  logic            mem_we;
  logic [W-1:0]    wb_rd;
  logic            wb_we;
  logic [NS*2-1:0] fwd_sel;
  logic            stall;
  logic            ex_bubble;
  logic            mc_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] m_sel [NS];
  int         m_busy;
  bit         m_lu_blk;

  fwd_hazard_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .MC_LAT(MCL)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_mc_start(ex_mc_start), .mem_rd(mem_rd), .mem_we(mem_we), .wb_rd(wb_rd),
    .wb_we(wb_we), .fwd_sel(fwd_sel), .stall(stall), .ex_bubble(ex_bubble),
    .mc_busy(mc_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hits(input int i, input logic [W-1:0] rd, input logic we);
    logic [W-1:0] a;
    a = id_rs_addr[i*W +: W];
    return id_rs_used[i] && we && (a == rd) && (a != 0);
  endfunction

  task automatic clear_in();
    id_valid = 1'b0; id_rs_addr = '0; id_rs_used = '0;
    ex_rd = '0; ex_we = 1'b0; ex_is_load = 1'b0; ex_mc_start = 1'b0;
    mem_rd = '0; mem_we = 1'b0; wb_rd = '0; wb_we = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_sel[i] = 2'b00;
    m_busy   = 0;
    m_lu_blk = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic [NS*2-1:0] exp_fs;
    logic [1:0]      nsel [NS];
    bit              lu, busy, start;
    @(negedge clk);
    busy  = (m_busy > 0);
    start = ex_mc_start;
    lu    = 1'b0;
    for (int i = 0; i < NS; i++) if (ex_is_load && hits(i, ex_rd, ex_we)) lu = 1'b1;
    lu = lu && id_valid && !m_lu_blk;
    for (int i = 0; i < NS; i++) exp_fs[2*i +: 2] = m_sel[i];
    chk("fwd_sel", 32'(fwd_sel), 32'(exp_fs));
    chk("stall", 32'(stall), 32'(lu || busy));
    chk("ex_bubble", 32'(ex_bubble), 32'(lu && !busy));
    chk("mc_busy", 32'(mc_busy), 32'(busy));
    for (int i = 0; i < NS; i++) begin
      nsel[i] = 2'b00;
      if (id_valid && !(lu || busy)) begin
        if (hits(i, ex_rd, ex_we))        nsel[i] = 2'b01;
        else if (hits(i, mem_rd, mem_we)) nsel[i] = 2'b10;
`ifdef FWD_WB_BYPASS_EN
        else if (hits(i, wb_rd, wb_we))   nsel[i] = 2'b11;
`endif
      end
    end
    @(posedge clk); #1;
    m_sel    = nsel;
    m_busy   = busy ? m_busy - 1 : (start ? MCL - 1 : 0);
    m_lu_blk = lu && !busy;
  endtask

  // Asynchronous reset between clock edges; outputs must clear without an edge.
  task automatic async_reset(input string tag);
    #2;
    clear_in();
    rst_n = 1'b0;
    #1;
    chk({tag, "_fwd_sel"}, 32'(fwd_sel), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_mc_busy"}, 32'(mc_busy), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    clear_in();
    model_reset();
    rst_n = 1'b0;
    #12;
    chk("rst_fwd_sel", 32'(fwd_sel), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_bubble", 32'(ex_bubble), 32'd0);
    chk("rst_mc_busy", 32'(mc_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // EX forwarding, and EX beats MEM
    id_valid = 1'b1; id_rs_addr = {5'd0, 5'd5}; id_rs_used = 2'b01;
    ex_rd = 5'd5; ex_we = 1'b1;
    cycle();
    chk("t1_ex_fwd", 32'(fwd_sel[1:0]), 32'd1);
    mem_rd = 5'd5; mem_we = 1'b1;
    cycle();
    chk("t1_ex_beats_mem", 32'(fwd_sel[1:0]), 32'd1);

    // x0 never forwarded, unused source never forwarded
    clear_in();
    id_valid = 1'b1; id_rs_addr = {5'd7, 5'd0}; id_rs_used = 2'b01;
    ex_rd = 5'd0; ex_we = 1'b1; mem_rd = 5'd7; mem_we = 1'b1;
    cycle();
    chk("t2_x0", 32'(fwd_sel[1:0]), 32'd0);
    chk("t2_unused", 32'(fwd_sel[3:2]), 32'd0);

    // load-use: one stall cycle, then MEM_WB forward
    clear_in();
    id_valid = 1'b1; id_rs_addr = {5'd3, 5'd0}; id_rs_used = 2'b10;
    ex_rd = 5'd3; ex_we = 1'b1; ex_is_load = 1'b1;
    #1;
    chk("t3_stall", 32'(stall), 32'd1);
    chk("t3_bubble", 32'(ex_bubble), 32'd1);
    cycle();
    ex_we = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; mem_rd = 5'd3; mem_we = 1'b1;
    #1;
    chk("t3_release", 32'(stall), 32'd0);
    cycle();
    chk("t3_mem_fwd", 32'(fwd_sel[3:2]), 32'd2);

    // multi-cycle occupancy
    clear_in();
    ex_mc_start = 1'b1;
    cycle();
    ex_mc_start = 1'b0;
    for (int k = 0; k < MCL - 1; k++) begin
      #1;
      chk("t4_busy", 32'(mc_busy), 32'd1);
      chk("t4_stall", 32'(stall), 32'd1);
      chk("t4_no_bubble", 32'(ex_bubble), 32'd0);
      cycle();
    end
    chk("t4_release", 32'(mc_busy), 32'd0);

    // reset in the middle of a count, and with a live forward select
    ex_mc_start = 1'b1;
    cycle();
    ex_mc_start = 1'b0;
    cycle();
    async_reset("t5_midcount");
    id_valid = 1'b1; id_rs_addr = {5'd0, 5'd6}; id_rs_used = 2'b01;
    ex_rd = 5'd6; ex_we = 1'b1;
    cycle();
    async_reset("t5_fwd");

    // WB-only match
    id_valid = 1'b1; id_rs_addr = {5'd0, 5'd9}; id_rs_used = 2'b01;
    wb_rd = 5'd9; wb_we = 1'b1;
    cycle();
    chk("t6_wb_only", 32'(fwd_sel[1:0]), 32'(WB_ONLY_EXP));

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) async_reset("rnd_reset");
      id_valid    = ($urandom_range(0, 9) != 0);
      id_rs_addr  = {W'($urandom_range(0, 7)), W'($urandom_range(0, 7))};
      id_rs_used  = NS'($urandom_range(0, 3));
      ex_rd       = W'($urandom_range(0, 7));
      ex_we       = ($urandom_range(0, 3) != 0);
      ex_is_load  = ($urandom_range(0, 2) == 0);
      ex_mc_start = (m_busy == 0) && ($urandom_range(0, 15) == 0);
      mem_rd      = W'($urandom_range(0, 7));
      mem_we      = $urandom_range(0, 1) == 1;
      wb_rd       = W'($urandom_range(0, 7));
      wb_we       = $urandom_range(0, 1) == 1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
